// File: rtl/trv_port_mux.sv
// Merges per-thread init-request streams into the traversal core (round-robin)
// and routes out-of-order traversal responses back by TID under per-thread credits.
module trv_port_mux_lane #(
    parameter int CW  = 3,
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic arst_n,
    input  logic req_read_i,
    input  logic rsp_hit_i,
    input  logic resp_full_n_i,
    output logic resp_write_o,
    output logic avail_o,
    output logic live_o
);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] credit_q, credit_d;

    assign resp_write_o = rsp_hit_i & resp_full_n_i;
    assign avail_o      = credit_q < MAX_C;
    // A response read alongside this lane's write must see the post-write count.
    assign live_o       = resp_write_o ? (credit_q > CW'(1)) : (credit_q != '0);

    always_comb begin
        credit_d = credit_q;
        unique case ({req_read_i, resp_write_o})
            2'b10:   credit_d = credit_q + CW'(1);
            2'b01:   credit_d = credit_q - CW'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) credit_q <= '0;
        else         credit_q <= credit_d;
    end
endmodule

module trv_port_mux #(
    parameter int NUM_THREADS         = 4,
    parameter int TID_WIDTH           = 3,
    parameter int CID_WIDTH           = 2,
    parameter int NUM_CONCURRENT_RAYS = 4,
    parameter int INIT_REQ_WIDTH      = 16,
    parameter int TRV_RESP_WIDTH      = 12
) (
    input  logic                                   clk,
    input  logic                                   arst_n,
    input  logic [NUM_THREADS-1:0]                 req_empty_n,
    output logic [NUM_THREADS-1:0]                 req_read,
    input  logic [NUM_THREADS*INIT_REQ_WIDTH-1:0]  req_dout,
    input  logic                                   init_req_stream_full_n,
    output logic                                   init_req_stream_write,
    output logic [INIT_REQ_WIDTH-1:0]              init_req_stream_din,
    input  logic                                   trv_resp_stream_empty_n,
    output logic                                   trv_resp_stream_read,
    input  logic [TRV_RESP_WIDTH-1:0]              trv_resp_stream_dout,
    input  logic [NUM_THREADS-1:0]                 resp_full_n,
    output logic [NUM_THREADS-1:0]                 resp_write,
    output logic [NUM_THREADS*TRV_RESP_WIDTH-1:0]  resp_din,
    output logic                                   err_tid
);
    localparam int NT = NUM_THREADS;
    localparam int TW = TID_WIDTH;
    localparam int IW = INIT_REQ_WIDTH;
    localparam int RW = TRV_RESP_WIDTH;

    logic          req_valid_q, req_valid_d;
    logic [IW-1:0] req_data_q, req_data_d;
    logic [TW-1:0] rr_last_q, rr_last_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [RW-1:0] rsp_data_q, rsp_data_d;
    logic [TW-1:0] rsp_tid_q, rsp_tid_d;
    logic          err_q, err_d;

    logic [NT-1:0] avail, live, elig, rsp_hit;
    logic          can_load, grant_vld, go, tid_ok, tid_live, rd;
    logic [TW-1:0] grant_idx, dout_tid;
    logic [IW-1:0] sel_req;

    for (genvar t = 0; t < NT; t++) begin : g_lane
        assign rsp_hit[t] = rsp_valid_q & (rsp_tid_q == TW'(t));
        trv_port_mux_lane #(.CW(CID_WIDTH + 1), .MAX(NUM_CONCURRENT_RAYS)) u_lane (
            .clk           (clk),
            .arst_n        (arst_n),
            .req_read_i    (req_read[t]),
            .rsp_hit_i     (rsp_hit[t]),
            .resp_full_n_i (resp_full_n[t]),
            .resp_write_o  (resp_write[t]),
            .avail_o       (avail[t]),
            .live_o        (live[t])
        );
    end

    assign init_req_stream_write = req_valid_q & init_req_stream_full_n;
    assign init_req_stream_din   = req_data_q;
    assign can_load              = ~req_valid_q | init_req_stream_write;
    assign elig                  = req_empty_n & avail;

    // Lowest eligible thread above rr_last wins; otherwise wrap to the lowest overall.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int t = NT - 1; t >= 0; t--) begin
            if (elig[t]) begin
                grant_vld = 1'b1;
                grant_idx = TW'(t);
            end
        end
        for (int t = NT - 1; t >= 0; t--) begin
            if (elig[t] && (t > int'(rr_last_q))) grant_idx = TW'(t);
        end
    end

    assign go       = grant_vld & can_load & arst_n;
    assign req_read = go ? (NT'(1) << grant_idx) : '0;

    assign dout_tid = trv_resp_stream_dout[TW-1:0];
    assign tid_ok   = int'(dout_tid) < NT;

    always_comb begin
        sel_req  = '0;
        tid_live = 1'b0;
        for (int t = 0; t < NT; t++) begin
            if (grant_idx == TW'(t)) sel_req  = req_dout[t*IW +: IW];
            if (dout_tid == TW'(t))  tid_live = live[t];
        end
    end

    assign rd                   = arst_n & trv_resp_stream_empty_n & (~rsp_valid_q | (|resp_write));
    assign trv_resp_stream_read = rd;
    assign resp_din             = {NT{rsp_data_q}};
    assign err_tid              = err_q;

    always_comb begin
        req_valid_d = req_valid_q;
        req_data_d  = req_data_q;
        rr_last_d   = rr_last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tid_d   = rsp_tid_q;
        err_d       = err_q;
        if (can_load) begin
            req_valid_d = go;
            if (go) begin
                req_data_d = sel_req;
                rr_last_d  = grant_idx;
                if (sel_req[TW-1:0] != grant_idx) err_d = 1'b1;
            end
        end
        if (rd) begin
            // Unroutable or uncredited responses are consumed and discarded.
            if (!tid_ok || !tid_live) begin
                rsp_valid_d = 1'b0;
                err_d       = 1'b1;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = trv_resp_stream_dout;
                rsp_tid_d   = dout_tid;
            end
        end else if (|resp_write) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            req_valid_q <= 1'b0;
            req_data_q  <= '0;
            rr_last_q   <= TW'(NT - 1);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tid_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_data_q  <= req_data_d;
            rr_last_q   <= rr_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tid_q   <= rsp_tid_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_trv_port_mux.sv
// Directed bench for trv_port_mux: queue-based reference model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_trv_port_mux;
    localparam int NT = 4;
    localparam int IW = 16;
    localparam int RW = 12;
    localparam int NCR = 4;

    logic            clk = 1'b0;
    logic            arst_n;
    logic [NT-1:0]   req_empty_n, req_read;
    logic [NT*IW-1:0] req_dout;
    logic            init_req_stream_full_n, init_req_stream_write;
    logic [IW-1:0]   init_req_stream_din;
    logic            trv_resp_stream_empty_n, trv_resp_stream_read;
    logic [RW-1:0]   trv_resp_stream_dout;
    logic [NT-1:0]   resp_full_n, resp_write;
    logic [NT*RW-1:0] resp_din;
    logic            err_tid;

    trv_port_mux #(.NUM_THREADS(NT), .TID_WIDTH(3), .CID_WIDTH(2), .NUM_CONCURRENT_RAYS(NCR),
                   .INIT_REQ_WIDTH(IW), .TRV_RESP_WIDTH(RW)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_empty_n(req_empty_n), .req_read(req_read), .req_dout(req_dout),
        .init_req_stream_full_n(init_req_stream_full_n),
        .init_req_stream_write(init_req_stream_write),
        .init_req_stream_din(init_req_stream_din),
        .trv_resp_stream_empty_n(trv_resp_stream_empty_n),
        .trv_resp_stream_read(trv_resp_stream_read),
        .trv_resp_stream_dout(trv_resp_stream_dout),
        .resp_full_n(resp_full_n), .resp_write(resp_write), .resp_din(resp_din),
        .err_tid(err_tid)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Environment sources
    logic [IW-1:0] src_mem [NT][32];
    int            hd [NT];
    int            tl [NT];
    logic [RW-1:0] rsrc [$];

    // Reference model
    logic [IW-1:0] mreq [$];
    logic [RW-1:0] mrsp [$];
    int            outst [NT];
    int            mlast;
    bit            merr;

    // Scenario observations
    int            glog [$];
    logic [NT-1:0] rwlog [$];
    int            n_w, n_trd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk_req(input int tid, input int tag);
        return {8'(tag), 5'b0, 3'(tid)};
    endfunction

    function automatic logic [RW-1:0] mk_rsp(input int tid, input int tag);
        return {7'(tag), 2'b0, 3'(tid)};
    endfunction

    task automatic push_req(input int t, input logic [IW-1:0] w);
        src_mem[t][tl[t]] = w;
        tl[t]++;
    endtask

    task automatic drive();
        for (int t = 0; t < NT; t++) begin
            req_empty_n[t]       = hd[t] < tl[t];
            req_dout[t*IW +: IW] = (hd[t] < tl[t]) ? src_mem[t][hd[t]] : '0;
        end
        trv_resp_stream_empty_n = rsrc.size() != 0;
        trv_resp_stream_dout    = (rsrc.size() != 0) ? rsrc[0] : '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive();
        end
    endtask

    task automatic clear_obs();
        glog.delete();
        rwlog.delete();
        n_w   = 0;
        n_trd = 0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        for (int t = 0; t < NT; t++) begin
            hd[t] = 0;
            tl[t] = 0;
        end
        rsrc.delete();
        drive();
        tick(2);
        arst_n = 1'b1;
        tick(1);
    endtask

    // Compare process: model outputs from current inputs, check, then advance model.
    initial begin
        logic [NT-1:0] e_rr, e_rw;
        bit            e_w, e_trd;
        int            g, tid, t;
        logic [IW-1:0] w;
        logic [RW-1:0] r;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                chk("reset_pops", {req_read, init_req_stream_write, trv_resp_stream_read, resp_write, err_tid}, '0);
                chk("reset_data", {init_req_stream_din, resp_din}, '0);
                mreq.delete();
                mrsp.delete();
                for (int i = 0; i < NT; i++) outst[i] = 0;
                mlast = NT - 1;
                merr  = 1'b0;
            end else begin
                e_w = (mreq.size() != 0) && init_req_stream_full_n;
                g = -1;
                if ((mreq.size() == 0) || e_w) begin
                    for (int k = 1; k <= NT; k++) begin
                        t = (mlast + k) % NT;
                        if (g < 0 && req_empty_n[t] && outst[t] < NCR) g = t;
                    end
                end
                e_rr = (g >= 0) ? NT'(1 << g) : '0;
                e_rw = '0;
                tid  = -1;
                if (mrsp.size() != 0) begin
                    tid = int'(mrsp[0][2:0]);
                    if (resp_full_n[tid]) e_rw[tid] = 1'b1;
                end
                e_trd = trv_resp_stream_empty_n && ((mrsp.size() == 0) || (e_rw != 0));

                chk("req_read", req_read, e_rr);
                chk("init_write", init_req_stream_write, e_w);
                if (mreq.size() != 0) chk("init_din", init_req_stream_din, mreq[0]);
                chk("resp_write", resp_write, e_rw);
                chk("trv_read", trv_resp_stream_read, e_trd);
                if (mrsp.size() != 0) chk("resp_din", resp_din, {NT{mrsp[0]}});
                chk("err_tid", err_tid, merr);

                // Environment: pop sources as the DUT did, log observations
                for (int i = 0; i < NT; i++) begin
                    if (req_read[i]) begin
                        glog.push_back(i);
                        if (hd[i] < tl[i]) hd[i]++;
                    end
                end
                if (trv_resp_stream_read && rsrc.size() != 0) begin
                    void'(rsrc.pop_front());
                    n_trd++;
                end
                if (init_req_stream_write) n_w++;
                if (resp_write != 0) rwlog.push_back(resp_write);

                // Model advance: writes free credit before the read is judged
                if (e_w) void'(mreq.pop_front());
                if (e_rw != 0) begin
                    outst[tid]--;
                    void'(mrsp.pop_front());
                end
                if (e_trd) begin
                    r = trv_resp_stream_dout;
                    tid = int'(r[2:0]);
                    if (tid >= NT || outst[tid] == 0) merr = 1'b1;
                    else mrsp.push_back(r);
                end
                if (g >= 0) begin
                    w = req_dout[g*IW +: IW];
                    mreq.push_back(w);
                    outst[g]++;
                    mlast = g;
                    if (int'(w[2:0]) != g) merr = 1'b1;
                end
            end
        end
    end

    initial begin
        int fo [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
        arst_n                 = 1'b0;
        init_req_stream_full_n = 1'b1;
        resp_full_n            = '1;
        req_empty_n            = '0;
        req_dout               = '0;
        for (int t = 0; t < NT; t++) begin
            hd[t] = 0;
            tl[t] = 0;
        end
        drive();
        tick(3);
        arst_n = 1'b1;
        tick(1);
        chk("err_after_reset", err_tid, 1'b0);

        // Single thread: three requests then three responses on thread 2
        clear_obs();
        for (int i = 0; i < 3; i++) push_req(2, mk_req(2, 16 + i));
        drive();
        tick(6);
        chk("single_writes", n_w, 3);
        chk("single_grants", glog.size(), 3);
        clear_obs();
        for (int i = 0; i < 3; i++) rsrc.push_back(mk_rsp(2, 32 + i));
        drive();
        tick(6);
        chk("single_rsp_cnt", rwlog.size(), 3);
        for (int i = 0; i < 3; i++) if (i < rwlog.size()) chk("single_rsp_dst", rwlog[i], 4'b0100);

        // Fairness: every thread saturates its credit, grants rotate from after thread 2
        clear_obs();
        for (int t = 0; t < NT; t++) for (int i = 0; i < NCR; i++) push_req(t, mk_req(t, 64 + 8*t + i));
        drive();
        tick(20);
        chk("fair_cnt", glog.size(), 16);
        chk("fair_writes", n_w, 16);
        for (int i = 0; i < 8; i++) if (i < glog.size()) chk("fair_order", glog[i], fo[i]);

        // Credit limit on thread 1, then one response buys exactly one more grant
        clear_obs();
        push_req(1, mk_req(1, 200));
        push_req(1, mk_req(1, 201));
        drive();
        tick(6);
        chk("credit_block", glog.size(), 0);
        rsrc.push_back(mk_rsp(1, 5));
        drive();
        tick(8);
        chk("credit_regrant_cnt", glog.size(), 1);
        if (glog.size() != 0) chk("credit_regrant_tid", glog[0], 1);
        hd[1] = tl[1];
        drive();

        // Backpressure on thread 0 blocks the response behind it
        clear_obs();
        resp_full_n = 4'b1110;
        rsrc.push_back(mk_rsp(0, 6));
        rsrc.push_back(mk_rsp(3, 7));
        drive();
        tick(5);
        chk("bp_no_write", rwlog.size(), 0);
        chk("bp_reads", n_trd, 1);
        resp_full_n = '1;
        tick(4);
        chk("bp_rel_cnt", rwlog.size(), 2);
        if (rwlog.size() == 2) begin
            chk("bp_rel_first", rwlog[0], 4'b0001);
            chk("bp_rel_second", rwlog[1], 4'b1000);
        end

        // Grant and response write to thread 0 in the same cycle
        clear_obs();
        rsrc.push_back(mk_rsp(0, 9));
        drive();
        tick(1);
        push_req(0, mk_req(0, 210));
        drive();
        tick(4);
        chk("simul_grants", glog.size(), 1);
        chk("simul_rsp", rwlog.size(), 1);

        // Core stalled: one request parks, no further pops
        clear_obs();
        init_req_stream_full_n = 1'b0;
        push_req(3, mk_req(3, 220));
        push_req(3, mk_req(3, 221));
        drive();
        tick(5);
        chk("stall_pops", glog.size(), 1);
        chk("stall_writes", n_w, 0);
        chk("stall_din", init_req_stream_din, mk_req(3, 220));
        init_req_stream_full_n = 1'b1;
        tick(3);
        chk("stall_release", n_w, 1);

        // Errors: out-of-range TID
        chk("err_clear", err_tid, 1'b0);
        clear_obs();
        rsrc.push_back(mk_rsp(6, 1));
        drive();
        tick(3);
        chk("err_bad_tid", err_tid, 1'b1);
        chk("err_bad_tid_drop", rwlog.size(), 0);
        tick(3);
        chk("err_sticky", err_tid, 1'b1);

        // Errors: response to a thread with no credit
        do_reset();
        chk("err_reset_clr", err_tid, 1'b0);
        clear_obs();
        rsrc.push_back(mk_rsp(2, 3));
        drive();
        tick(3);
        chk("err_no_credit", err_tid, 1'b1);
        chk("err_no_credit_drop", rwlog.size(), 0);

        // Errors: mismatched TID on a granted request is still forwarded
        do_reset();
        clear_obs();
        push_req(1, mk_req(0, 77));
        drive();
        tick(3);
        chk("err_req_tid", err_tid, 1'b1);
        chk("err_req_fwd", n_w, 1);

        // Reset with work in flight discards everything
        rsrc.push_back(mk_rsp(1, 2));
        push_req(2, mk_req(2, 78));
        drive();
        tick(1);
        do_reset();
        clear_obs();
        tick(4);
        chk("midrst_writes", n_w, 0);
        chk("midrst_rsp", rwlog.size(), 0);
        chk("midrst_err", err_tid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
